// File: rtl/data_mem_ctrl.sv
// Data-memory controller: wait-state sequenced single-port RAM access with registered read data.
// Optional sticky out-of-range flag AddrErr is enabled by defining MEM_BOUNDS_CHECK_EN.
module data_mem_ctrl #(
   parameter int WIDTH       = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] ARout,
   input  logic [WIDTH-1:0]  BusOut,
   input  logic              MemRd,
   input  logic              MemWr,
   output logic [WIDTH-1:0]  DataOut,
   output logic              Busy,
   output logic              Done
`ifdef MEM_BOUNDS_CHECK_EN
   ,output logic             AddrErr
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state_q;
   logic [3:0]        waitCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  wdata_q;
   logic [WIDTH-1:0]  dataOut_q;
   logic              isWrite_q;
   logic              busy_q;
   logic              done_q;
`ifdef MEM_BOUNDS_CHECK_EN
   logic              addrErr_q;
`endif

   logic [WIDTH-1:0]  mem [DEPTH];

   logic              addrInRange_d;
   logic              reqInRange_d;
   logic              ramWrEn_d;

   always_comb begin
      addrInRange_d = int'(addr_q) < DEPTH;
      reqInRange_d  = int'(ARout) < DEPTH;
      ramWrEn_d     = !Rst && (state_q == S_ACCESS) && isWrite_q && addrInRange_d;
   end

   // RAM contents survive reset; the write enable is blocked by Rst so an aborted write never lands.
   always_ff @(posedge Clk) begin
      if (ramWrEn_d) begin
         mem[addr_q] <= wdata_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         waitCnt_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         dataOut_q <= '0;
         isWrite_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
         addrErr_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (MemRd || MemWr) begin
                  // Write wins a collision; address and data are frozen here for the whole access.
                  addr_q    <= ARout;
                  wdata_q   <= BusOut;
                  isWrite_q <= MemWr;
                  busy_q    <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
                  if (reqInRange_d) begin
                     addrErr_q <= 1'b0;
                  end
`endif
                  if (WAIT_CYCLES == 0) begin
                     state_q   <= S_ACCESS;
                     waitCnt_q <= '0;
                  end else begin
                     state_q   <= S_WAIT;
                     waitCnt_q <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (waitCnt_q == 4'd1) begin
                  state_q   <= S_ACCESS;
                  waitCnt_q <= '0;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
               end
            end
            S_ACCESS: begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               if (!isWrite_q) begin
                  dataOut_q <= addrInRange_d ? mem[addr_q] : '0;
               end
`ifdef MEM_BOUNDS_CHECK_EN
               if (!addrInRange_d) begin
                  addrErr_q <= 1'b1;
               end
`endif
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      DataOut = dataOut_q;
      Busy    = busy_q;
      Done    = done_q;
`ifdef MEM_BOUNDS_CHECK_EN
      AddrErr = addrErr_q;
`endif
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl: default timing, WAIT_CYCLES=0 and DEPTH=128 instances.
module tb_data_mem_ctrl;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [7:0] ARout, BusOut;
   logic       rd0, wr0, rd1, wr1, rd2, wr2;
   logic [7:0] dout0, dout1, dout2;
   logic       busy0, busy1, busy2;
   logic       done0, done1, done2;
`ifdef MEM_BOUNDS_CHECK_EN
   logic       aerr0, aerr1, aerr2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   data_mem_ctrl #(.WIDTH(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u0 (
      .Clk(Clk), .Rst(Rst), .ARout(ARout), .BusOut(BusOut), .MemRd(rd0), .MemWr(wr0),
      .DataOut(dout0), .Busy(busy0), .Done(done0)
`ifdef MEM_BOUNDS_CHECK_EN
      , .AddrErr(aerr0)
`endif
   );

   data_mem_ctrl #(.WIDTH(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
      .Clk(Clk), .Rst(Rst), .ARout(ARout), .BusOut(BusOut), .MemRd(rd1), .MemWr(wr1),
      .DataOut(dout1), .Busy(busy1), .Done(done1)
`ifdef MEM_BOUNDS_CHECK_EN
      , .AddrErr(aerr1)
`endif
   );

   data_mem_ctrl #(.WIDTH(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u2 (
      .Clk(Clk), .Rst(Rst), .ARout(ARout), .BusOut(BusOut), .MemRd(rd2), .MemWr(wr2),
      .DataOut(dout2), .Busy(busy2), .Done(done2)
`ifdef MEM_BOUNDS_CHECK_EN
      , .AddrErr(aerr2)
`endif
   );

   // Issues one request to the chosen instance and measures, in edges after E0, the Busy
   // cycles seen and the edge at which Done rose. Returns sampling just after Done rose.
   task automatic runAccess(input int which, input logic r, input logic w,
                            input logic [7:0] a, input logic [7:0] d,
                            output int busyCycles, output int doneAt);
      logic b, dn;
      @(negedge Clk);
      ARout  = a;
      BusOut = d;
      case (which)
         0:       begin rd0 = r; wr0 = w; end
         1:       begin rd1 = r; wr1 = w; end
         default: begin rd2 = r; wr2 = w; end
      endcase
      @(posedge Clk);
      @(negedge Clk);
      rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
      busyCycles = 0;
      doneAt     = -1;
      for (int k = 0; k < 20 && doneAt < 0; k++) begin
         if (k > 0) @(negedge Clk);
         b  = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
         dn = (which == 0) ? done0 : (which == 1) ? done1 : done2;
         if (b)  busyCycles++;
         if (dn) doneAt = k;
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy0 got %b want 0", busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done0 got %b want 0", done0); end
      checks++; if (dout0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout0 got %h want 00", dout0); end
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || dout1 !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_u1 got busy=%b done=%b dout=%h want 0 0 00", busy1, done1, dout1);
      end
      checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || dout2 !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_u2 got busy=%b done=%b dout=%h want 0 0 00", busy2, done2, dout2);
      end
`ifdef MEM_BOUNDS_CHECK_EN
      checks++; if (aerr2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_addrerr got %b want 0", aerr2); end
`endif
   endtask

   task automatic test_write_read();
      int bc, da;
      runAccess(0, 1'b0, 1'b1, 8'h10, 8'hAA, bc, da);
      checks++; if (bc !== 3) begin errors++; $display("[TB] FAIL wr_busy_cycles got %0d want 3", bc); end
      checks++; if (da !== 3) begin errors++; $display("[TB] FAIL wr_done_edge got %0d want 3", da); end
      checks++; if (dout0 !== 8'h00) begin errors++; $display("[TB] FAIL wr_dout_held got %h want 00", dout0); end
      runAccess(0, 1'b1, 1'b0, 8'h10, 8'h00, bc, da);
      checks++; if (bc !== 3) begin errors++; $display("[TB] FAIL rd_busy_cycles got %0d want 3", bc); end
      checks++; if (da !== 3) begin errors++; $display("[TB] FAIL rd_done_edge got %0d want 3", da); end
      checks++; if (dout0 !== 8'hAA) begin errors++; $display("[TB] FAIL rd_data got %h want AA", dout0); end
      @(negedge Clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle got %b want 0", done0); end
   endtask

   task automatic test_busy_ignore();
      int bc, da;
      bit seen;
      @(negedge Clk);
      ARout = 8'h10; BusOut = 8'hAA; wr0 = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      BusOut = 8'h55;
      @(posedge Clk);
      @(negedge Clk);
      wr0 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done0) seen = 1'b1;
         else @(negedge Clk);
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL busy_ign_done got %b want 1", seen); end
      runAccess(0, 1'b1, 1'b0, 8'h10, 8'h00, bc, da);
      checks++; if (dout0 !== 8'hAA) begin errors++; $display("[TB] FAIL busy_ign_data got %h want AA", dout0); end
   endtask

   task automatic test_collision();
      int bc, da;
      runAccess(0, 1'b1, 1'b1, 8'h20, 8'h3C, bc, da);
      checks++; if (da !== 3) begin errors++; $display("[TB] FAIL coll_done_edge got %0d want 3", da); end
      checks++; if (dout0 !== 8'hAA) begin errors++; $display("[TB] FAIL coll_dout_held got %h want AA", dout0); end
      runAccess(0, 1'b1, 1'b0, 8'h20, 8'h00, bc, da);
      checks++; if (dout0 !== 8'h3C) begin errors++; $display("[TB] FAIL coll_readback got %h want 3C", dout0); end
   endtask

   task automatic test_reset_mid_access();
      int bc, da;
      runAccess(0, 1'b0, 1'b1, 8'h30, 8'h11, bc, da);
      @(negedge Clk);
      ARout = 8'h30; BusOut = 8'h77; wr0 = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      wr0 = 1'b0;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before got %b want 1", busy0); end
      Rst = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy0, done0);
      end
      checks++; if (dout0 !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_dout got %h want 00", dout0); end
      repeat (4) @(negedge Clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_done got %b want 0", done0); end
      runAccess(0, 1'b1, 1'b0, 8'h30, 8'h00, bc, da);
      checks++; if (dout0 !== 8'h11) begin errors++; $display("[TB] FAIL rst_mid_readback got %h want 11", dout0); end
   endtask

   task automatic test_zero_wait();
      int bc, da;
      runAccess(1, 1'b0, 1'b1, 8'h05, 8'h5A, bc, da);
      checks++; if (bc !== 1) begin errors++; $display("[TB] FAIL zw_wr_busy got %0d want 1", bc); end
      checks++; if (da !== 1) begin errors++; $display("[TB] FAIL zw_wr_done got %0d want 1", da); end
      runAccess(1, 1'b1, 1'b0, 8'h05, 8'h00, bc, da);
      checks++; if (bc !== 1) begin errors++; $display("[TB] FAIL zw_rd_busy got %0d want 1", bc); end
      checks++; if (da !== 1) begin errors++; $display("[TB] FAIL zw_rd_done got %0d want 1", da); end
      checks++; if (dout1 !== 8'h5A) begin errors++; $display("[TB] FAIL zw_rd_data got %h want 5A", dout1); end
   endtask

   task automatic test_bounds();
      int bc, da;
      runAccess(2, 1'b0, 1'b1, 8'h10, 8'h42, bc, da);
      runAccess(2, 1'b1, 1'b0, 8'h10, 8'h00, bc, da);
      checks++; if (dout2 !== 8'h42) begin errors++; $display("[TB] FAIL oob_inrange_data got %h want 42", dout2); end
      runAccess(2, 1'b0, 1'b1, 8'h90, 8'h99, bc, da);
      checks++; if (da !== 3) begin errors++; $display("[TB] FAIL oob_wr_done got %0d want 3", da); end
      runAccess(2, 1'b1, 1'b0, 8'h90, 8'h00, bc, da);
      checks++; if (da !== 3) begin errors++; $display("[TB] FAIL oob_rd_done got %0d want 3", da); end
      checks++; if (dout2 !== 8'h00) begin errors++; $display("[TB] FAIL oob_rd_data got %h want 00", dout2); end
`ifdef MEM_BOUNDS_CHECK_EN
      checks++; if (aerr2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_addrerr_set got %b want 1", aerr2); end
      repeat (3) @(negedge Clk);
      checks++; if (aerr2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_addrerr_sticky got %b want 1", aerr2); end
`endif
      runAccess(2, 1'b1, 1'b0, 8'h10, 8'h00, bc, da);
      checks++; if (dout2 !== 8'h42) begin errors++; $display("[TB] FAIL oob_no_alias got %h want 42", dout2); end
`ifdef MEM_BOUNDS_CHECK_EN
      checks++; if (aerr2 !== 1'b0) begin errors++; $display("[TB] FAIL oob_addrerr_clear got %b want 0", aerr2); end
`endif
   endtask

   initial begin
      Rst = 1'b1; ARout = '0; BusOut = '0;
      rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
      test_reset();
      test_write_read();
      test_busy_ignore();
      test_collision();
      test_reset_mid_access();
      test_zero_wait();
      test_bounds();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
